// File: rtl/byte_sub_shift_row.sv
// AES encryption-round stage: SubBytes followed by ShiftRows, performed in
// place on the 32-word statemt RAM (state byte (row i, col j) lives in the
// low byte of word 4*j+i). Each row is read (two ports, two cycles),
// captured, then written back substituted and rotated left by the row index.
//
// Handshake: ap_start is sampled only in IDLE. ap_idle is high while IDLE
// and ap_start is low. ap_done and ap_ready pulse together for one cycle
// at the end of a run. ap_start held high during DONE does not restart the
// block until the following IDLE cycle.
module byte_sub_shift_row #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 32
) (
   input  logic              ap_clk,
   input  logic              ap_rst_n,
   input  logic              ap_start,
   output logic              ap_done,
   output logic              ap_idle,
   output logic              ap_ready,
   output logic [ADDR_W-1:0] statemt_address0,
   output logic              statemt_ce0,
   output logic              statemt_we0,
   output logic [DATA_W-1:0] statemt_d0,
   input  logic [DATA_W-1:0] statemt_q0,
   output logic [ADDR_W-1:0] statemt_address1,
   output logic              statemt_ce1,
   output logic              statemt_we1,
   output logic [DATA_W-1:0] statemt_d1,
   input  logic [DATA_W-1:0] statemt_q1,
   output logic [6:0]        dbg_state_o
);

   // One-hot state encoding
   localparam logic [6:0] S_IDLE = 7'b0000001;
   localparam logic [6:0] S_RD_A = 7'b0000010;
   localparam logic [6:0] S_RD_B = 7'b0000100;
   localparam logic [6:0] S_CAP  = 7'b0001000;
   localparam logic [6:0] S_WR_A = 7'b0010000;
   localparam logic [6:0] S_WR_B = 7'b0100000;
   localparam logic [6:0] S_DONE = 7'b1000000;

   // FIPS-197 forward S-box; byte for input 0x00 sits in the top bits.
   localparam logic [2047:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   function automatic logic [7:0] sbox(input logic [7:0] x);
      return SBOX[(255 - int'(x)) * 8 +: 8];
   endfunction

   logic [6:0] state_q, state_d;
   logic [1:0] r_q, r_d;
   logic [7:0] b_q [4];
   logic [7:0] b_d [4];

   logic [3:0] addr0_lo, addr1_lo;
   logic [1:0] idx0, idx1;
   logic [7:0] s0, s1;

   // Only the low state byte of each word is meaningful; upper read bits
   // are deliberately discarded.
   logic unused_q_hi;
   assign unused_q_hi = ^{statemt_q0[DATA_W-1:8], statemt_q1[DATA_W-1:8]};

   assign s0 = sbox(b_q[idx0]);
   assign s1 = sbox(b_q[idx1]);

   assign ap_idle     = state_q[0] & ~ap_start;
   assign ap_ready    = ap_done;
   assign dbg_state_o = state_q;

   assign statemt_address0 = ADDR_W'(addr0_lo);
   assign statemt_address1 = ADDR_W'(addr1_lo);
   assign statemt_d0       = {{(DATA_W-8){1'b0}}, s0};
   assign statemt_d1       = {{(DATA_W-8){1'b0}}, s1};

   // Next-state, RAM port control and byte capture
   always_comb begin
      state_d     = state_q;
      r_d         = r_q;
      b_d         = b_q;
      statemt_ce0 = 1'b0;
      statemt_ce1 = 1'b0;
      statemt_we0 = 1'b0;
      statemt_we1 = 1'b0;
      addr0_lo    = 4'd0;
      addr1_lo    = 4'd0;
      idx0        = 2'd0;
      idx1        = 2'd0;
      ap_done     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (ap_start) begin
               state_d = S_RD_A;
               r_d     = 2'd0;
            end
         end
         S_RD_A: begin
            statemt_ce0 = 1'b1;
            statemt_ce1 = 1'b1;
            addr0_lo    = {2'd0, r_q};
            addr1_lo    = {2'd1, r_q};
            state_d     = S_RD_B;
         end
         S_RD_B: begin
            statemt_ce0 = 1'b1;
            statemt_ce1 = 1'b1;
            addr0_lo    = {2'd2, r_q};
            addr1_lo    = {2'd3, r_q};
            b_d[0]      = statemt_q0[7:0];
            b_d[1]      = statemt_q1[7:0];
            state_d     = S_CAP;
         end
         S_CAP: begin
            b_d[2]  = statemt_q0[7:0];
            b_d[3]  = statemt_q1[7:0];
            state_d = S_WR_A;
         end
         S_WR_A: begin
            statemt_ce0 = 1'b1;
            statemt_ce1 = 1'b1;
            statemt_we0 = 1'b1;
            statemt_we1 = 1'b1;
            addr0_lo    = {2'd0, r_q};
            addr1_lo    = {2'd1, r_q};
            idx0        = r_q;
            idx1        = r_q + 2'd1;
            state_d     = S_WR_B;
         end
         S_WR_B: begin
            statemt_ce0 = 1'b1;
            statemt_ce1 = 1'b1;
            statemt_we0 = 1'b1;
            statemt_we1 = 1'b1;
            addr0_lo    = {2'd2, r_q};
            addr1_lo    = {2'd3, r_q};
            idx0        = r_q + 2'd2;
            idx1        = r_q + 2'd3;
            if (r_q == 2'd3) begin
               state_d = S_DONE;
            end else begin
               r_d     = r_q + 2'd1;
               state_d = S_RD_A;
            end
         end
         S_DONE: begin
            ap_done = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State, row counter and captured row bytes
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         state_q <= S_IDLE;
         r_q     <= 2'd0;
         for (int k = 0; k < 4; k++) b_q[k] <= 8'd0;
      end else begin
         state_q <= state_d;
         r_q     <= r_d;
         for (int k = 0; k < 4; k++) b_q[k] <= b_d[k];
      end
   end

endmodule
